midori_shared_ctrl: RTL and testbench

Sequencing and I/O stage sitting directly upstream of `midori_shared_main`: it accepts a 3-share Midori64 plaintext over a valid/ready handshake and applies input whitening on share 1. It drives `start_sel` and `round` to the shared round datapath for 15 keyed rounds plus the final S-layer pass, then captures the three ciphertext shares with output whitening and holds them on a valid/ready output. The key is unshared, as in the datapath. The plaintext and ciphertext shares are never recombined inside this block.

---
 rtl/midori_shared_ctrl.sv | 155 +++++++++++++++
 tb/tb_midori_shared_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/midori_shared_ctrl.sv
// Sequencing and I/O control for the 3-share Midori64 round datapath.
// Accepts plaintext shares, applies input whitening to share 1, steps the
// datapath through 15 keyed rounds and one final S-layer period, then captures
// and holds the output-whitened ciphertext shares until the consumer takes them.
// Shares are never recombined here.
module midori_shared_ctrl #(
    parameter int unsigned NL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] pt_1,
    input  logic [63:0] pt_2,
    input  logic [63:0] pt_3,
    input  logic [63:0] MK0,
    input  logic [63:0] MK1,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] ct_1,
    output logic [63:0] ct_2,
    output logic [63:0] ct_3,

    output logic        busy,

    output logic        start_sel,
    output logic [3:0]  round,
    output logic [63:0] state_1st,
    output logic [63:0] state_2nd,
    output logic [63:0] state_3rd,
    input  logic [63:0] ciphertext_1,
    input  logic [63:0] ciphertext_2,
    input  logic [63:0] ciphertext_3
);

    // Wide enough to hold 0..NL_LAT, never zero width.
    localparam int unsigned PW = $clog2(NL_LAT + 2);
    localparam logic [PW-1:0] PCNT_LAST = PW'(NL_LAT);
    localparam logic [3:0] LAST_KEYED = 4'd14;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [3:0]    rcnt, rcnt_nxt;
    logic [PW-1:0] pcnt, pcnt_nxt;
    logic          out_valid_nxt;
    logic          capture;
    logic          period_end;
    logic [63:0]   wk;

    assign wk = MK0 ^ MK1;

    // Whitening touches only share 1 so the sharing stays valid.
    assign state_1st = pt_1 ^ wk;
    assign state_2nd = pt_2;
    assign state_3rd = pt_3;

    assign period_end = (pcnt == PCNT_LAST);

    // Next-state, counter and capture decode.
    always_comb begin
        state_nxt     = state;
        rcnt_nxt      = rcnt;
        pcnt_nxt      = pcnt;
        out_valid_nxt = out_valid;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = ROUND;
                    rcnt_nxt  = 4'd0;
                    pcnt_nxt  = '0;
                end
            end
            ROUND: begin
                if (period_end) begin
                    pcnt_nxt = '0;
                    rcnt_nxt = rcnt + 4'd1;
                    if (rcnt == LAST_KEYED) begin
                        state_nxt = FINAL;
                    end
                end else begin
                    pcnt_nxt = pcnt + 1'b1;
                end
            end
            FINAL: begin
                if (period_end) begin
                    pcnt_nxt      = '0;
                    capture       = 1'b1;
                    out_valid_nxt = 1'b1;
                    state_nxt     = DONE;
                end else begin
                    pcnt_nxt = pcnt + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    rcnt_nxt      = 4'd0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rcnt      <= 4'd0;
            pcnt      <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            rcnt      <= rcnt_nxt;
            pcnt      <= pcnt_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // Ciphertext capture with output whitening on share 1; held until handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ct_1 <= 64'd0;
            ct_2 <= 64'd0;
            ct_3 <= 64'd0;
        end else if (capture) begin
            ct_1 <= ciphertext_1 ^ wk;
            ct_2 <= ciphertext_2;
            ct_3 <= ciphertext_3;
        end
    end

    // Datapath steering and status; round must stay constant for a whole period.
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        start_sel = (state == IDLE);
        round     = 4'd0;
        if (state == ROUND) begin
            round = rcnt;
        end else if (state == FINAL) begin
            round = 4'd15;
        end
    end

endmodule

// File: tb/tb_midori_shared_ctrl.sv
// Bench for midori_shared_ctrl: contains a behavioural shared-datapath stand-in
// (register + NL_LAT pipeline, re-shared with fresh masks) and a plain Midori64
// reference used for the expected ciphertext.
module tb_midori_shared_ctrl;

    localparam int unsigned NL_LAT = 2;
    localparam int unsigned P      = NL_LAT + 1;
    localparam int unsigned LAT    = 16 * P + 1;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [63:0] pt_1, pt_2, pt_3, mk0, mk1;
    logic        out_valid, out_ready;
    logic [63:0] ct_1, ct_2, ct_3;
    logic        busy, start_sel;
    logic [3:0]  round;
    logic [63:0] state_1st, state_2nd, state_3rd;
    logic [63:0] ciphertext_1, ciphertext_2, ciphertext_3;

    int checks = 0;
    int errors = 0;

    midori_shared_ctrl #(.NL_LAT(NL_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .pt_1(pt_1), .pt_2(pt_2), .pt_3(pt_3), .MK0(mk0), .MK1(mk1),
        .out_valid(out_valid), .out_ready(out_ready),
        .ct_1(ct_1), .ct_2(ct_2), .ct_3(ct_3),
        .busy(busy), .start_sel(start_sel), .round(round),
        .state_1st(state_1st), .state_2nd(state_2nd), .state_3rd(state_3rd),
        .ciphertext_1(ciphertext_1), .ciphertext_2(ciphertext_2),
        .ciphertext_3(ciphertext_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- Midori64 building blocks ----------------
    function automatic logic [3:0] sb(input logic [3:0] v);
        logic [63:0] t;
        t = 64'hcad3ebf789150246;
        return t[63 - 4 * int'(v) -: 4];
    endfunction

    function automatic logic [63:0] sub_cell(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[63 - 4 * i -: 4] = sb(x[63 - 4 * i -: 4]);
        return y;
    endfunction

    function automatic logic [63:0] shuffle(input logic [63:0] x);
        logic [63:0] perm, y;
        logic [3:0]  src;
        perm = 64'h0a5fe4b193c67d28;
        for (int i = 0; i < 16; i++) begin
            src = perm[63 - 4 * i -: 4];
            y[63 - 4 * i -: 4] = x[63 - 4 * int'(src) -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] mix_col(input logic [63:0] x);
        logic [63:0] y;
        logic [3:0]  t;
        for (int j = 0; j < 4; j++) begin
            t = 4'd0;
            for (int k = 0; k < 4; k++) t ^= x[63 - 4 * (4 * j + k) -: 4];
            for (int k = 0; k < 4; k++)
                y[63 - 4 * (4 * j + k) -: 4] = t ^ x[63 - 4 * (4 * j + k) -: 4];
        end
        return y;
    endfunction

    function automatic logic [15:0] alpha(input int r);
        case (r)
            0: return 16'h15b3;   1: return 16'h78c0;   2: return 16'ha435;
            3: return 16'h6213;   4: return 16'h104f;   5: return 16'hd170;
            6: return 16'h0266;   7: return 16'h0bcc;   8: return 16'h9481;
            9: return 16'h40b8;  10: return 16'h7197;  11: return 16'h228e;
           12: return 16'h5130;  13: return 16'hf8ca;  14: return 16'hdf90;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [63:0] round_key(input int r, input logic [63:0] k0, k1);
        logic [63:0] rc;
        logic [15:0] a;
        a  = alpha(r);
        rc = 64'd0;
        for (int i = 0; i < 16; i++) rc[60 - 4 * i] = a[15 - i];
        return ((r % 2) == 1 ? k1 : k0) ^ rc;
    endfunction

    function automatic logic [63:0] midori_enc(input logic [63:0] pt, k0, k1);
        logic [63:0] s;
        s = pt ^ k0 ^ k1;
        for (int r = 0; r < 15; r++) s = mix_col(shuffle(sub_cell(s))) ^ round_key(r, k0, k1);
        return sub_cell(s) ^ k0 ^ k1;
    endfunction

    // Datapath stand-in output function for the period selected by round.
    function automatic logic [63:0] dp_out(input logic [3:0] r, input logic [63:0] x,
                                           input logic [63:0] k0, k1);
        if (r == 4'd15) return sub_cell(x);
        return mix_col(shuffle(sub_cell(x))) ^ round_key(int'(r), k0, k1);
    endfunction

    // ---------------- Shared datapath stand-in ----------------
    logic [63:0] sr1, sr2, sr3, m2, m3, dp_f;
    logic [63:0] pipe [NL_LAT];

    always @(posedge clk) begin
        if (start_sel) begin
            sr1 <= state_1st; sr2 <= state_2nd; sr3 <= state_3rd;
        end else begin
            sr1 <= ciphertext_1; sr2 <= ciphertext_2; sr3 <= ciphertext_3;
        end
        pipe[0] <= sr1 ^ sr2 ^ sr3;
        for (int k = 1; k < NL_LAT; k++) pipe[k] <= pipe[k-1];
        m2 <= {$urandom(), $urandom()};
        m3 <= {$urandom(), $urandom()};
    end

    assign dp_f         = dp_out(round, pipe[NL_LAT-1], mk0, mk1);
    assign ciphertext_1 = dp_f ^ m2 ^ m3;
    assign ciphertext_2 = m2;
    assign ciphertext_3 = m3;

    // ---------------- Checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_shares(input logic [63:0] pt);
        logic [63:0] s2, s3;
        s2 = {$urandom(), $urandom()};
        s3 = {$urandom(), $urandom()};
        pt_1 = pt ^ s2 ^ s3;
        pt_2 = s2;
        pt_3 = s3;
    endtask

    // Presents a block at a negedge and returns in cycle 1 after the accept edge.
    task automatic accept(input logic [63:0] pt, input logic [63:0] k0, k1);
        int w;
        mk0 = k0;
        mk1 = k1;
        load_shares(pt);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [63:0] pt, k0, k1, exp,
                       input int stall, input bit trace);
        int n;
        logic [63:0] h1, h2, h3;
        logic [3:0]  exp_round;
        out_ready = (stall == 0);
        accept(pt, k0, k1);
        n = 1;
        while (!out_valid && n < 400) begin
            if (trace) begin
                exp_round = (n <= 15 * int'(P)) ? 4'((n - 1) / int'(P)) : 4'd15;
                check("trace_round", {60'd0, round}, {60'd0, exp_round});
                check("trace_start_sel", {63'd0, start_sel}, 64'd0);
                check("trace_busy", {63'd0, busy}, 64'd1);
                if (n == 10) begin
                    in_valid = 1'b1;
                    load_shares({$urandom(), $urandom()});
                end
                if (n == 11) in_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        check({tag, "_ct"}, ct_1 ^ ct_2 ^ ct_3, exp);
        check({tag, "_excl"}, {63'd0, in_ready & out_valid}, 64'd0);
        h1 = ct_1; h2 = ct_2; h3 = ct_3;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_ct", {ct_1, ct_2, ct_3} == {h1, h2, h3} ? 64'd1 : 64'd0, 64'd1);
            check("stall_valid", {62'd0, out_valid, in_ready}, 64'd2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_idle"}, {61'd0, out_valid, in_ready, busy}, 64'd2);
    endtask

    // ---------------- Directed sequence ----------------
    localparam logic [63:0] KA_K0 = 64'h687ded3b3c85b3f3;
    localparam logic [63:0] KA_K1 = 64'h5b1009863e2a8cbf;
    localparam logic [63:0] KA_PT = 64'h42c20fd3b586879e;
    localparam logic [63:0] KA_CT = 64'h66bcdc6270d901cd;

    initial begin
        logic [63:0] rp, rk0, rk1;
        int n;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        pt_1 = '0; pt_2 = '0; pt_3 = '0; mk0 = '0; mk1 = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out", {60'd0, out_valid, busy, round[0], |round}, 64'd0);
        check("rst_ct", ct_1 | ct_2 | ct_3, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {62'd0, in_ready, start_sel}, 64'd3);

        run("kat0", 64'd0, 64'd0, 64'd0, 64'h3c9cceda2bbd449a, 0, 1'b1);
        for (int i = 0; i < 3; i++) run("kat1", KA_PT, KA_K0, KA_K1, KA_CT, 0, 1'b0);

        // Held output, then back-to-back block as soon as IDLE is reached.
        run("stall", KA_PT, KA_K0, KA_K1, KA_CT, 20, 1'b0);
        rp = {$urandom(), $urandom()};
        run("b2b", rp, KA_K0, KA_K1, midori_enc(rp, KA_K0, KA_K1), 0, 1'b0);

        // Abort in round 7 with an asynchronous reset.
        out_ready = 1'b1;
        accept(KA_PT, KA_K0, KA_K1);
        n = 1;
        while (n < 7 * int'(P) + 2) begin
            @(negedge clk);
            n++;
        end
        check("abort_round", {60'd0, round}, 64'd7);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out", {60'd0, out_valid, busy, |round, 1'b0}, 64'd0);
        check("abort_ct", ct_1 | ct_2 | ct_3, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", {62'd0, in_ready, start_sel}, 64'd3);
        run("post_abort", 64'd0, 64'd0, 64'd0, 64'h3c9cceda2bbd449a, 0, 1'b0);

        // Random keys and plaintexts against the reference.
        for (int i = 0; i < 4; i++) begin
            rp  = {$urandom(), $urandom()};
            rk0 = {$urandom(), $urandom()};
            rk1 = {$urandom(), $urandom()};
            run("rand", rp, rk0, rk1, midori_enc(rp, rk0, rk1), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
